// File: rtl/peg_l2_mac_pfc_pkg.sv
// Shared constants and types for the L2 MAC pause / PFC timer bank.
package peg_l2_mac_pfc_pkg;

  // Bit times in one pause quantum (802.3 Annex 31B).
  localparam int unsigned MAC_PAUSE_QUANTA_BITS = 512;

  // MAC control opcodes recognised by the RX parser.
  localparam logic [15:0] MAC_OPCODE_PAUSE = 16'h0001;
  localparam logic [15:0] MAC_OPCODE_PFC   = 16'h0101;

  // RX parser field indices for pause-related fields.
  localparam int unsigned MAC_FIDX_PAUSE_TIME    = 3;
  localparam int unsigned MAC_FIDX_PFC_CLASS_VEC = 4;
  localparam int unsigned MAC_FIDX_PFC_TIME      = 5;

  // One pause-time field as carried on the wire.
  typedef logic [15:0] pfc_quanta_t;

  // Width of a tick counter able to hold 0..ticks-1; never narrower than one bit.
  function automatic int unsigned tick_cnt_width(input int unsigned ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/peg_l2_mac_pfc_class_timer.sv
// Pause timer for a single priority class: quanta counter plus bit-time tick prescaler.
module peg_l2_mac_pfc_class_timer
  import peg_l2_mac_pfc_pkg::*;
#(
  parameter int unsigned QuantaW = 16,
  parameter int unsigned Ticks   = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [QuantaW-1:0] time_i,
  output logic               valid_o,
  output logic               done_o
);

  localparam int unsigned TickW = tick_cnt_width(Ticks);
  localparam logic [TickW-1:0] TickMax = TickW'(Ticks - 1);

  logic [QuantaW-1:0] quanta_q, quanta_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic               done_q, done_d;

  // Next state: clear beats load, load beats countdown; done only on a natural expiry.
  always_comb begin
    quanta_d = quanta_q;
    tick_d   = tick_q;
    done_d   = 1'b0;
    if (clr_i) begin
      quanta_d = '0;
      tick_d   = '0;
    end else if (load_i) begin
      // A reload replaces the remaining time; it never accumulates.
      quanta_d = time_i;
      tick_d   = '0;
    end else if (quanta_q != '0) begin
      if (tick_q == TickMax) begin
        tick_d   = '0;
        quanta_d = quanta_q - 1'b1;
        done_d   = (quanta_q == QuantaW'(1));
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quanta_q <= '0;
      tick_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      quanta_q <= quanta_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  assign valid_o = (quanta_q != '0);
  assign done_o  = done_q;

endmodule

// File: rtl/peg_l2_mac_pfc_cntr.sv
// Per-priority pause timer bank (802.3x / 802.1Qbb) for the L2 MAC RX path.
module peg_l2_mac_pfc_cntr
  import peg_l2_mac_pfc_pkg::*;
#(
  parameter int unsigned BPCLK       = 8,
  parameter int unsigned NUM_CLASSES = 8,
  parameter int unsigned QUANTA_W    = 16,
  parameter int unsigned QUANTA_BITS = MAC_PAUSE_QUANTA_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pfc_en,
  input  logic [NUM_CLASSES-1:0]          class_en,
  input  logic                            pause_flush,
  input  logic                            pause_time_valid,
  input  logic                            pause_legacy,
  input  logic [NUM_CLASSES-1:0]          pause_class_vec,
  input  logic [NUM_CLASSES*QUANTA_W-1:0] pause_time,
  output logic [NUM_CLASSES-1:0]          pause_valid,
  output logic                            pause_any,
  output logic [NUM_CLASSES-1:0]          pause_done
);

  // Clock cycles per pause quantum.
  localparam int unsigned TICKS = QUANTA_BITS / BPCLK;

  logic [NUM_CLASSES-1:0] load;
  logic [NUM_CLASSES-1:0] clr;

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_class
    logic [QUANTA_W-1:0] time_sel;

    // Legacy 802.3x frames carry a single time in field 0 that applies to every enabled class.
    assign time_sel = pause_legacy ? pause_time[0 +: QUANTA_W]
                                   : pause_time[i*QUANTA_W +: QUANTA_W];

    assign load[i] = pause_time_valid & pfc_en & class_en[i]
                   & (pause_legacy | pause_class_vec[i]);
    assign clr[i]  = ~pfc_en | ~class_en[i] | pause_flush;

    peg_l2_mac_pfc_class_timer #(
      .QuantaW (QUANTA_W),
      .Ticks   (TICKS)
    ) u_timer (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clr_i   (clr[i]),
      .load_i  (load[i]),
      .time_i  (time_sel),
      .valid_o (pause_valid[i]),
      .done_o  (pause_done[i])
    );
  end

  assign pause_any = |pause_valid;

endmodule

// File: doc/peg_l2_mac_pfc_cntr.md
Name: peg_l2_mac_pfc_cntr

Overview:
Per-priority pause timer bank for the L2 MAC RX path. It generalises the single-class 802.3x pause counter to N traffic classes (802.1Qbb PFC), parametrised in data width and quanta size.
- Loads per-class pause quanta from the RX parser when a valid pause/PFC frame is decoded.
- Counts the quanta down in bit-time units.
- Drives per-class pause status to MAC TX and the LLC scheduler.
- Legacy 802.3x frames are handled in the same block by broadcasting one time to all enabled classes.

Parameters:
BPCLK, 8, bits transferred per clk on the MAC datapath; power of 2, 8..512.
NUM_CLASSES, 8, number of priority classes; 1..8.
QUANTA_W, 16, width of one pause-time field.
QUANTA_BITS, 512, bit times per pause quantum; must be a multiple of BPCLK.

Ports:
clk  in  1  MAC clock
rst_n  in  1  asynchronous active-low reset
pfc_en  in  1  global enable; low clears all timers
class_en  in  NUM_CLASSES  per-class enable mask
pause_flush  in  1  clears all timers (link down / config change)
pause_time_valid  in  1  single-cycle strobe from parser; pause fields valid and FCS good
pause_legacy  in  1  qualifies strobe: 802.3x frame; time field 0 applies to all classes
pause_class_vec  in  NUM_CLASSES  PFC class-enable vector from frame
pause_time  in  NUM_CLASSES*QUANTA_W  packed times; class i at [i*QUANTA_W +: QUANTA_W]
pause_valid  out  NUM_CLASSES  class i currently paused
pause_any  out  1  OR of pause_valid
pause_done  out  NUM_CLASSES  one-cycle pulse when class i timer expires naturally

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all counters 0; pause_valid, pause_any and pause_done all 0.
- Derived constant: TICKS = QUANTA_BITS/BPCLK cycles per quantum (64 at defaults).
- Per-class state: quanta_cnt[QUANTA_W] and tick_cnt[log2(TICKS)]. Implicit FSM:
  - IDLE: quanta_cnt == 0.
  - PAUSED: quanta_cnt != 0.
- pause_valid[i] = (quanta_cnt[i] != 0), decoded from flops only.
- Load condition for class i: pause_time_valid & pfc_en & class_en[i] & (pause_legacy | pause_class_vec[i]).
  - On load: quanta_cnt <= (pause_legacy ? time field 0 : time field i); tick_cnt <= 0.
  - A load replaces the current value; it never accumulates.
- Latency: a strobe sampled at edge k makes pause_valid visible after edge k (1-cycle latency).
- Duration: time T keeps pause_valid high for exactly T*TICKS cycles.
- Countdown in PAUSED:
  - tick_cnt increments each cycle.
  - When tick_cnt == TICKS-1: tick_cnt <= 0 and quanta_cnt decrements.
  - If that decrement reaches 0, pause_done[i] <= 1 for one cycle, coinciding with pause_valid falling.
- Load with T = 0: class goes to IDLE next cycle (immediate resume); no pause_done.
- Load on the same edge as the final decrement: the load wins; no pause_done.
- Clear conditions: pfc_en low, class_en[i] low, or pause_flush high clears class i next edge.
  - Clear has priority over load; no pause_done.
- Classes with the strobe but a masked vector bit are untouched.
- Async reset mid-pause clears everything immediately.
- No saturation is needed: counters only load or decrement.

Decomposition:
- Package peg_l2_mac_pfc_pkg:
  - MAC_PAUSE_QUANTA_BITS = 512
  - MAC_OPCODE_PAUSE = 16'h0001
  - MAC_OPCODE_PFC = 16'h0101
  - MAC_FIDX_PFC_CLASS_VEC and MAC_FIDX_PFC_TIME parser field indices, alongside the existing MAC_FIDX_PAUSE_TIME
  - typedef pfc_quanta_t (logic [15:0])
- Sub-module peg_l2_mac_pfc_class_timer: one class's counter pair, load/clear/done logic. Instantiated NUM_CLASSES times by generate. The top holds load qualification, the legacy mux and pause_any.

Test Plan:
- Defaults; strobe, legacy=0, class_vec=8'h04, time[2]=1 -> pause_valid=8'h04 for exactly 64 cycles; pause_done[2] pulses on cycle 64; all other bits 0.
- time[5]=10 loaded; after 100 cycles reload time[5]=2 -> pause_valid[5] lasts 128 more cycles; only one pause_done[5] pulse.
- Class 1 paused with time=50; strobe time[1]=0 -> pause_valid[1] low next cycle; no pause_done.
- legacy=1, time[0]=3, class_en=8'h0F, class_vec=8'h00 -> pause_valid=8'h0F for 192 cycles; pause_any high for the same window.
- All classes paused; pause_flush pulse (then separately pfc_en low, and a same-cycle strobe) -> all clear next cycle; strobe ignored; no pause_done.
- BPCLK=64, time=16'hFFFF on class 7 -> pause_valid[7] high for 524280 cycles; repeat with rst_n asserted mid-pause -> outputs 0 immediately.
